// File: rtl/flo144_dec_if.sv
// flo144_dec_if: index-stream in / vector-result out bundle for flo144_dec.
//   s_valid/s_ready/s_index/s_last : index beat stream (8-bit bit positions)
//   m_valid/m_ready/m_vec/m_count/m_err : frame result
//   m_thermo (only with FLO144_DEC_THERMO_EN) : thermometer of highest set bit
// Modports: slave = the decoder, master = the side driving beats / consuming results.
interface flo144_dec_if #(
  parameter int unsigned WID  = 144,
  parameter int unsigned CNTW = 8
) ();
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      s_index;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [WID-1:0]  m_vec;
  logic [CNTW-1:0] m_count;
  logic            m_err;
`ifdef FLO144_DEC_THERMO_EN
  logic [WID-1:0]  m_thermo;
`endif

  modport slave (
    input  s_valid, s_index, s_last, m_ready,
    output s_ready, m_valid, m_vec, m_count, m_err
`ifdef FLO144_DEC_THERMO_EN
    , output m_thermo
`endif
  );

  modport master (
    output s_valid, s_index, s_last, m_ready,
    input  s_ready, m_valid, m_vec, m_count, m_err
`ifdef FLO144_DEC_THERMO_EN
    , input m_thermo
`endif
  );
endinterface

// File: rtl/flo144_dec.sv
// flo144_dec: rebuilds a WID-bit vector from a framed stream of bit indices
// (0..WID-1 set a bit, 255 = none, anything else flags an error).
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous abort of a partial frame (ignored while a result is held)
//   bus    : flo144_dec_if.slave (index stream in, frame result out)
// Optional: define FLO144_DEC_THERMO_EN to add bus.m_thermo, bits [h:0] set
// where h is the highest set bit of m_vec.
module flo144_dec #(
  parameter int unsigned WID  = 144,
  parameter int unsigned CNTW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  flo144_dec_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e          state_q, state_d;
  logic [WID-1:0]  acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [WID-1:0]  vec_q, vec_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            merr_q, merr_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;

  logic            accept_c;
  logic            in_range_c;
  logic            is_none_c;
  logic [WID-1:0]  onehot_c;
  logic [WID-1:0]  acc_new_c;
  logic [CNTW-1:0] cnt_new_c;
  logic            err_new_c;

  // Effect of the current beat on the accumulator, count and error flag.
  always_comb begin
    accept_c   = bus.s_valid & s_ready_q;
    in_range_c = 32'(bus.s_index) < WID;
    is_none_c  = (bus.s_index == 8'd255);
    onehot_c   = in_range_c ? (WID'(1) << bus.s_index) : '0;
    acc_new_c  = acc_q | onehot_c;
    // Only a bit that was previously clear adds to the distinct count.
    cnt_new_c  = cnt_q + CNTW'(|(onehot_c & ~acc_q));
    err_new_c  = err_q | (~in_range_c & ~is_none_c);
  end

`ifdef FLO144_DEC_THERMO_EN
  logic [WID-1:0] thermo_q, thermo_d;
  logic [WID-1:0] thermo_c;
  logic           run_c;

  // Prefix-OR from the MSB down: every bit at or below the highest one is set.
  always_comb begin
    run_c    = 1'b0;
    thermo_c = '0;
    for (int i = int'(WID) - 1; i >= 0; i--) begin
      run_c       = run_c | acc_new_c[i];
      thermo_c[i] = run_c;
    end
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vec_d   = vec_q;
    count_d = count_q;
    merr_d  = merr_q;
`ifdef FLO144_DEC_THERMO_EN
    thermo_d = thermo_q;
`endif
    unique case (state_q)
      IDLE, ACCUM: begin
        if (clr) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (accept_c) begin
          acc_d = acc_new_c;
          cnt_d = cnt_new_c;
          err_d = err_new_c;
          if (bus.s_last) begin
            state_d = HOLD;
            vec_d   = acc_new_c;
            count_d = cnt_new_c;
            merr_d  = err_new_c;
`ifdef FLO144_DEC_THERMO_EN
            thermo_d = thermo_c;
`endif
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d != HOLD);
    m_valid_d = (state_d == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      vec_q     <= '0;
      count_q   <= '0;
      merr_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
`ifdef FLO144_DEC_THERMO_EN
      thermo_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vec_q     <= vec_d;
      count_q   <= count_d;
      merr_q    <= merr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
`ifdef FLO144_DEC_THERMO_EN
      thermo_q  <= thermo_d;
`endif
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_vec   = vec_q;
  assign bus.m_count = count_q;
  assign bus.m_err   = merr_q;
`ifdef FLO144_DEC_THERMO_EN
  assign bus.m_thermo = thermo_q;
`endif

endmodule

// File: tb/tb_flo144_dec.sv
// tb_flo144_dec: directed self-checking bench for flo144_dec.
module tb_flo144_dec;
  localparam int unsigned WID  = 144;
  localparam int unsigned CNTW = 8;

  logic clk;
  logic rst_n;
  logic clr;
  int   checks;
  int   errors;

  flo144_dec_if #(.WID(WID), .CNTW(CNTW)) bus ();

  flo144_dec #(.WID(WID), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge; returns at the negedge after acceptance.
  task automatic beat(input logic [7:0] idx, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_index = idx;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout observed=s_ready_low expected=s_ready_high");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_index = 8'd0;
  endtask

  // Check a held result, then hand it off.
  task automatic take(input string tag, input logic [WID-1:0] ev, input logic [31:0] ec,
                      input logic ee);
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
    chk_vec({tag, "_vec"}, bus.m_vec, ev);
    chk({tag, "_count"}, 32'(bus.m_count), ec);
    chk({tag, "_err"}, 32'(bus.m_err), 32'(ee));
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.s_ready), 32'd1);
  endtask

  logic [WID-1:0] e;
  logic [WID-1:0] held;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    clr         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_index = 8'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk_vec("rst_m_vec", bus.m_vec, '0);
    chk("rst_m_count", 32'(bus.m_count), 32'd0);
    chk("rst_m_err", 32'(bus.m_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

    // Frame {5, 143, 0(last)}
    beat(8'd5, 1'b0);
    beat(8'd143, 1'b0);
    chk("f1_no_early_valid", 32'(bus.m_valid), 32'd0);
    beat(8'd0, 1'b1);
    e = '0; e[0] = 1'b1; e[5] = 1'b1; e[143] = 1'b1;
`ifdef FLO144_DEC_THERMO_EN
    chk_vec("f1_thermo", bus.m_thermo, {WID{1'b1}});
`endif
    take("f1", e, 32'd3, 1'b0);

    // Frame {7, 7, 7(last)}: duplicates counted once
    beat(8'd7, 1'b0);
    beat(8'd7, 1'b0);
    beat(8'd7, 1'b1);
    e = '0; e[7] = 1'b1;
    take("f2", e, 32'd1, 1'b0);

    // Frame {255(last)}: empty result
    beat(8'd255, 1'b1);
`ifdef FLO144_DEC_THERMO_EN
    chk_vec("f3_thermo", bus.m_thermo, '0);
`endif
    take("f3", '0, 32'd0, 1'b0);

    // Frame {144(last)}: first out-of-range index
    beat(8'd144, 1'b1);
    take("f4", '0, 32'd0, 1'b1);

    // Frame {10, 200, 12(last)}, then hold with m_ready low
    beat(8'd10, 1'b0);
    beat(8'd200, 1'b0);
    beat(8'd12, 1'b1);
    e = '0; e[10] = 1'b1; e[12] = 1'b1;
`ifdef FLO144_DEC_THERMO_EN
    chk_vec("f5_thermo", bus.m_thermo, {{(WID-13){1'b0}}, 13'h1fff});
`endif
    held = bus.m_vec;
    bus.s_valid = 1'b1;
    bus.s_index = 8'd20;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
      chk("hold_m_valid", 32'(bus.m_valid), 32'd1);
      chk_vec("hold_m_vec", bus.m_vec, e);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    take("f5", e, 32'd2, 1'b1);
    chk_vec("after_hs_vec_kept", bus.m_vec, held);

    // Frame {1(last)}: accumulator must have been cleared
    beat(8'd1, 1'b1);
    e = '0; e[1] = 1'b1;
    take("f6", e, 32'd1, 1'b0);

    // Mid-frame clr with a concurrent beat that must be dropped
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b0);
    clr         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_index = 8'd20;
    bus.s_last  = 1'b1;
    @(negedge clk);
    clr         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("clr_no_valid", 32'(bus.m_valid), 32'd0);
    beat(8'd9, 1'b1);
    e = '0; e[9] = 1'b1;
    // clr while holding is ignored
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_hold_valid", 32'(bus.m_valid), 32'd1);
    take("f7", e, 32'd1, 1'b0);

    // Mid-frame asynchronous reset
    beat(8'd30, 1'b0);
    beat(8'd31, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mrst_s_ready", 32'(bus.s_ready), 32'd0);
    chk_vec("mrst_m_vec", bus.m_vec, '0);
    chk("mrst_m_count", 32'(bus.m_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_valid", 32'(bus.m_valid), 32'd0);
    end

    // Frame {47(last)} after reset: prior partial beats gone
    beat(8'd47, 1'b1);
    e = '0; e[47] = 1'b1;
`ifdef FLO144_DEC_THERMO_EN
    chk_vec("f8_thermo", bus.m_thermo, {{(WID-48){1'b0}}, 48'hffff_ffff_ffff});
`endif
    take("f8", e, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flo144_dec.md
Name: flo144_dec

Overview:
- Inverse of the team's 144-bit find-last-one encoder: rebuilds a 144-bit vector from a stream of 8-bit bit indices.
- Uses the same index convention as the encoder: 0..143 is a bit position, 8'd255 means "no bit".
- Indices arrive over a valid/ready stream grouped into frames. Each completed frame is presented as one vector on an output valid/ready port.
- Sits downstream of index queues, e.g. free-list and bitmap reconstruction in allocators and schedulers.

Parameters:
- WID, 144, vector width; legal range 1..255, index 255 reserved as "none".
- CNTW, 8, width of the distinct-bit count; must satisfy 2**CNTW > WID.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserted asynchronously, released synchronously by the system.
- s_valid  input  1  index beat valid.
- s_ready  output  1  block accepts a beat this cycle.
- s_index  input  8  bit index; 0..WID-1 sets a bit, 255 is a no-op, anything else is an error.
- s_last  input  1  beat closes the current frame.
- m_valid  output  1  frame result valid.
- m_ready  input  1  consumer accepts the result.
- m_vec  output  WID  reconstructed vector.
- m_count  output  CNTW  number of distinct bits set in m_vec.
- m_err  output  1  frame contained at least one out-of-range index.
- clr  input  1  synchronous abort: discard the partial frame and return to IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, accumulator=0, count=0, err=0, s_ready=0, m_valid=0, m_vec=0, m_count=0, m_err=0.
- States:
  - IDLE: s_ready=1, waiting for the first beat.
  - ACCUM: s_ready=1, frame open.
  - HOLD: s_ready=0, m_valid=1, result held for the consumer.
- A beat is accepted when s_valid & s_ready. On each accepted beat:
  - idx<WID: acc[idx] is set. count increments only if acc[idx] was 0 before this beat, so duplicates are not counted.
  - idx==255: no change. A frame consisting only of 255 beats yields m_vec=0, m_count=0, m_err=0.
  - WID<=idx<255: vector unchanged, err is set sticky for the frame.
- State transitions:
  - IDLE -> ACCUM on an accepted beat with s_last=0.
  - IDLE/ACCUM -> HOLD on an accepted beat with s_last=1.
  - The final beat's effect is included in the result.
  - Single-beat frames are legal.
- Latency: the cycle after the s_last beat is accepted, m_valid=1 and m_vec/m_count/m_err are registered and stable.
- Result hold:
  - Outputs hold until m_valid & m_ready.
  - On that edge: m_valid=0, accumulator/count/err clear, state -> IDLE, and s_ready=1 from the next cycle.
  - There is one bubble cycle between frames; back-to-back results are not required.
- m_vec and m_count are registered copies taken at frame close. They do not change while m_valid=1 and are not cleared after the handshake.
- clr priority: clr is above beat acceptance. In IDLE/ACCUM it clears the accumulator, count and err, the beat in the same cycle is dropped, and state -> IDLE. In HOLD, clr is ignored and the held result stands.
- Mid-frame reset: rst_n low discards everything immediately. No partial m_valid ever appears.
- Count saturation: not reachable, since distinct bits <= WID < 2**CNTW.

Optional Feature:
- Macro: FLO144_DEC_THERMO_EN.
- Defined:
  - Adds output m_thermo [WID-1:0], registered at frame close alongside m_vec.
  - m_thermo has bits [h:0] set, where h is the highest set bit of m_vec; it is all zeros when m_vec==0.
  - Feeding m_vec back through the encoder yields h.
  - m_thermo follows the same reset and hold rules as m_vec.
- Not defined: port absent; no thermometer logic synthesised.

Test Plan:
- Reset, then frame {5, 143, 0(last)} -> m_valid one cycle after the last beat; m_vec bits 0,5,143 set; m_count=3; m_err=0.
- Frame {7, 7, 7(last)} -> m_vec has bit 7 only; m_count=1.
- Frame {255(last)} -> m_vec=0, m_count=0, m_err=0; with THERMO_EN, m_thermo=0.
- Frame {10, 200, 12(last)} -> m_vec bits 10,12; m_count=2; m_err=1.
- Hold m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0 and outputs stable. Then m_ready=1 -> m_valid drops; the next frame {1(last)} gives m_vec=0x2 with bit 10 absent.
- Mid-frame clr: {3, 4}, clr, {9(last)} -> m_vec bit 9 only, m_count=1. Mid-frame rst_n pulse -> all outputs 0 and no m_valid. With THERMO_EN, frame {47(last)} -> m_thermo bits [47:0] set.
